// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues data-bus loads/stores via req/ack, stalls the front end while busy,
// and registers GPR/CSR writeback. Optional alignment trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_csr_we,
  input  logic [11:0] mem_csr_waddr,
  input  logic [31:0] mem_csr_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_maddr,
  input  logic [31:0] mem_sdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        stall_req,
  output logic        misalign,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        wb_we,
  output logic        wb_csr_we,
  output logic [11:0] wb_csr_waddr,
  output logic [31:0] wb_csr_wdata
);

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic        op_valid_s;
  logic        op_load_s;
  logic        op_store_s;
  logic        op_signed_s;
  logic [1:0]  op_size_s;
  logic        misalign_s;
  logic        issue_s;

  logic        dbus_req_nxt_s;
  logic        dbus_we_nxt_s;
  logic [31:0] dbus_addr_nxt_s;
  logic [3:0]  dbus_be_nxt_s;
  logic [31:0] dbus_wdata_nxt_s;
  logic        misalign_nxt_s;
  logic [31:0] wb_wdata_nxt_s;
  logic        wb_we_nxt_s;
  logic        wb_csr_we_nxt_s;

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: lane_be = 4'b0001 << a;
      SZ_HALF: lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: store_rep = {4{d[7:0]}};
      SZ_HALF: store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic sgn,
                                           input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rd >> {a, 3'b000};
    b = shifted[7:0];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_BYTE: load_ext = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      SZ_HALF: load_ext = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: load_ext = rd;
    endcase
  endfunction

  // Decode the memory opcode into direction, access size and signedness
  always_comb begin
    op_valid_s  = 1'b1;
    op_load_s   = 1'b0;
    op_store_s  = 1'b0;
    op_signed_s = 1'b0;
    op_size_s   = SZ_WORD;
    case (mem_op)
      4'd1: begin op_load_s = 1'b1;  op_signed_s = 1'b1; op_size_s = SZ_BYTE; end
      4'd2: begin op_load_s = 1'b1;  op_signed_s = 1'b1; op_size_s = SZ_HALF; end
      4'd3: begin op_load_s = 1'b1;  op_size_s = SZ_WORD; end
      4'd4: begin op_load_s = 1'b1;  op_size_s = SZ_BYTE; end
      4'd5: begin op_load_s = 1'b1;  op_size_s = SZ_HALF; end
      4'd6: begin op_store_s = 1'b1; op_size_s = SZ_BYTE; end
      4'd7: begin op_store_s = 1'b1; op_size_s = SZ_HALF; end
      4'd8: begin op_store_s = 1'b1; op_size_s = SZ_WORD; end
      default: op_valid_s = 1'b0;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  // Flag halfword/word accesses whose low address bits break natural alignment
  always_comb begin
    misalign_s = 1'b0;
    if (op_valid_s) begin
      case (op_size_s)
        SZ_HALF: misalign_s = mem_maddr[0];
        SZ_WORD: misalign_s = |mem_maddr[1:0];
        default: misalign_s = 1'b0;
      endcase
    end else begin
      misalign_s = 1'b0;
    end
  end
`else
  assign misalign_s = 1'b0;
`endif

  assign issue_s = (state_r == ST_IDLE) && op_valid_s && !misalign_s;

  // State register; reset abandons any outstanding transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (dbus_ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: stall request plus next values for every registered output
  always_comb begin
    stall_req        = 1'b0;
    dbus_req_nxt_s   = dbus_req;
    dbus_we_nxt_s    = dbus_we;
    dbus_addr_nxt_s  = dbus_addr;
    dbus_be_nxt_s    = dbus_be;
    dbus_wdata_nxt_s = dbus_wdata;
    misalign_nxt_s   = 1'b0;
    wb_wdata_nxt_s   = mem_wdata;
    wb_we_nxt_s      = 1'b0;
    wb_csr_we_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          stall_req        = 1'b1;
          dbus_req_nxt_s   = 1'b1;
          dbus_we_nxt_s    = op_store_s;
          dbus_addr_nxt_s  = {mem_maddr[31:2], 2'b00};
          dbus_be_nxt_s    = lane_be(op_size_s, mem_maddr[1:0]);
          dbus_wdata_nxt_s = store_rep(op_size_s, mem_sdata);
        end else if (op_valid_s) begin
          // only reachable for a trapped misaligned access: drop it, no writeback
          misalign_nxt_s = 1'b1;
        end else begin
          wb_we_nxt_s     = mem_we;
          wb_csr_we_nxt_s = mem_csr_we;
        end
      end
      ST_BUSY: begin
        if (dbus_ack) begin
          dbus_req_nxt_s  = 1'b0;
          wb_we_nxt_s     = mem_we;
          wb_csr_we_nxt_s = mem_csr_we;
          if (op_load_s) begin
            wb_wdata_nxt_s = load_ext(op_size_s, op_signed_s, mem_maddr[1:0], dbus_rdata);
          end else begin
            wb_wdata_nxt_s = mem_wdata;
          end
        end else begin
          stall_req = 1'b1;
        end
      end
      default: stall_req = 1'b0;
    endcase
  end

  // Registered bus and writeback outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= 32'd0;
      dbus_be      <= 4'd0;
      dbus_wdata   <= 32'd0;
      misalign     <= 1'b0;
      wb_waddr     <= 5'd0;
      wb_wdata     <= 32'd0;
      wb_we        <= 1'b0;
      wb_csr_we    <= 1'b0;
      wb_csr_waddr <= 12'd0;
      wb_csr_wdata <= 32'd0;
    end else begin
      dbus_req     <= dbus_req_nxt_s;
      dbus_we      <= dbus_we_nxt_s;
      dbus_addr    <= dbus_addr_nxt_s;
      dbus_be      <= dbus_be_nxt_s;
      dbus_wdata   <= dbus_wdata_nxt_s;
      misalign     <= misalign_nxt_s;
      wb_waddr     <= mem_waddr;
      wb_wdata     <= wb_wdata_nxt_s;
      wb_we        <= wb_we_nxt_s;
      wb_csr_we    <= wb_csr_we_nxt_s;
      wb_csr_waddr <= mem_csr_waddr;
      wb_csr_wdata <= mem_csr_wdata;
    end
  end

endmodule
